// File: rtl/and_sweep_ctrl_if.sv
// Control/result bundle plus gate pins for the AND self-test sequencer.
// master = boot controller and gate side, slave = the sequencer.
interface and_sweep_ctrl_if #(
   parameter int ERR_W = 8
);
   logic             start;
   logic             abort;
   logic             gate_out;
   logic             gate_a;
   logic             gate_b;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic [1:0]       fail_vec;
   logic             fail_valid;

   modport master (
      output start, abort, gate_out,
      input  gate_a, gate_b, busy, done, pass, err_count, fail_vec, fail_valid
   );

   modport slave (
      input  start, abort, gate_out,
      output gate_a, gate_b, busy, done, pass, err_count, fail_vec, fail_valid
   );
endinterface

// File: rtl/and_sweep_ctrl.sv
// Sweeps a 2-input AND gate through 00..11 for LOOPS passes, HOLD_CYCLES per vector, and scores it.
// Latency: run lasts 4*HOLD_CYCLES*LOOPS cycles then a 1-cycle done; no backpressure, abort ends a run early.
module and_sweep_ctrl #(
   parameter int HOLD_CYCLES = 4,
   parameter int LOOPS       = 1,
   parameter int ERR_W       = 8
) (
   input logic           clk,
   input logic           rst_n,
   and_sweep_ctrl_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [LW-1:0] LOOP_LAST = LW'(LOOPS - 1);

   logic [1:0]       state;
   logic [HW-1:0]    hold_cnt;
   logic [LW-1:0]    loop_cnt;
   logic [1:0]       vec;
   logic [ERR_W-1:0] err_count;
   logic [1:0]       fail_vec;
   logic             fail_valid;
   logic             pass;

   logic             sample;
   logic             mismatch;
   logic             last_vec;
   logic             last_loop;
   logic             finish;
   logic [ERR_W-1:0] err_next;

   // vec doubles as the registered {gate_a, gate_b} drive, so the compare uses exactly what the gate sees
   always_comb begin
      sample    = (state == ST_RUN) && (hold_cnt == HOLD_LAST);
      mismatch  = sample && (bus.gate_out != (vec[1] & vec[0]));
      last_vec  = (vec == 2'b11);
      last_loop = (loop_cnt == LOOP_LAST);
      finish    = sample && last_vec && last_loop;
      err_next  = err_count;
      if (mismatch && !(&err_count)) begin
         err_next = err_count + ERR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         hold_cnt   <= '0;
         loop_cnt   <= '0;
         vec        <= 2'b00;
         err_count  <= '0;
         fail_vec   <= 2'b00;
         fail_valid <= 1'b0;
         pass       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start && !bus.abort) begin
                  state      <= ST_RUN;
                  hold_cnt   <= '0;
                  loop_cnt   <= '0;
                  vec        <= 2'b00;
                  err_count  <= '0;
                  fail_vec   <= 2'b00;
                  fail_valid <= 1'b0;
                  pass       <= 1'b0;
               end
            end

            ST_RUN: begin
               // scoring happens even on the abort edge so a last-moment mismatch is not lost
               err_count <= err_next;
               if (mismatch && !fail_valid) begin
                  fail_vec   <= vec;
                  fail_valid <= 1'b1;
               end

               if (bus.abort) begin
                  state    <= ST_IDLE;
                  hold_cnt <= '0;
                  loop_cnt <= '0;
                  vec      <= 2'b00;
                  pass     <= 1'b0;
               end else if (sample) begin
                  hold_cnt <= '0;
                  vec      <= vec + 2'd1;
                  if (last_vec) begin
                     loop_cnt <= last_loop ? '0 : loop_cnt + LW'(1);
                  end
                  if (finish) begin
                     state <= ST_DONE;
                     pass  <= (err_next == '0);
                  end
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.gate_a     = vec[1];
   assign bus.gate_b     = vec[0];
   assign bus.busy       = (state == ST_RUN);
   assign bus.done       = (state == ST_DONE);
   assign bus.pass       = pass;
   assign bus.err_count  = err_count;
   assign bus.fail_vec   = fail_vec;
   assign bus.fail_valid = fail_valid;

   a_done_pulse : assert property (@(posedge clk) disable iff (!rst_n)
      bus.done |=> !bus.done);
   a_gate_idle : assert property (@(posedge clk) disable iff (!rst_n)
      !bus.busy |-> (vec == 2'b00));
   a_err_implies_fail : assert property (@(posedge clk) disable iff (!rst_n)
      (err_count != '0) |-> fail_valid);
endmodule

// File: tb/tb_and_sweep_ctrl.sv
// Directed bench: four sequencer instances, each paired with a different gate model.
module tb_and_sweep_ctrl;
   logic clk;
   logic rst_n;

   logic       start      [4];
   logic       abort      [4];
   logic       busy       [4];
   logic       done       [4];
   logic       pass       [4];
   logic       fail_valid [4];
   logic       ga         [4];
   logic       gb         [4];
   logic [1:0] fvec       [4];
   logic [7:0] errc       [4];

   int checks;
   int errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 0: correct AND, H4 L1 | 1: stuck-at-1, H2 | 2: OR gate, L2 | 3: stuck-at-0, ERR_W 2, L4
   for (genvar i = 0; i < 4; i++) begin : g_dut
      localparam int H = (i == 1) ? 2 : 4;
      localparam int L = (i == 2) ? 2 : (i == 3) ? 4 : 1;
      localparam int E = (i == 3) ? 2 : 8;

      and_sweep_ctrl_if #(.ERR_W(E)) bus ();

      and_sweep_ctrl #(
         .HOLD_CYCLES (H),
         .LOOPS       (L),
         .ERR_W       (E)
      ) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus.slave)
      );

      assign bus.start    = start[i];
      assign bus.abort    = abort[i];
      assign bus.gate_out = (i == 0) ? (bus.gate_a & bus.gate_b) :
                            (i == 1) ? 1'b1 :
                            (i == 2) ? (bus.gate_a | bus.gate_b) : 1'b0;
      assign busy[i]       = bus.busy;
      assign done[i]       = bus.done;
      assign pass[i]       = bus.pass;
      assign fail_valid[i] = bus.fail_valid;
      assign ga[i]         = bus.gate_a;
      assign gb[i]         = bus.gate_b;
      assign fvec[i]       = bus.fail_vec;
      assign errc[i]       = 8'(bus.err_count);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int d);
      start[d] = 1'b1;
      tick();
      start[d] = 1'b0;
   endtask

   // Walks a run from RUN cycle c0 until busy drops, checking the vector schedule on the way.
   task automatic run_to_end(input int d, input int hold, input int c0, output int nbusy);
      int n;
      int bad;
      logic [1:0] expv;
      n   = c0;
      bad = 0;
      while (busy[d] && n < 300) begin
         expv = 2'((n / hold) % 4);
         if ({ga[d], gb[d]} != expv) bad++;
         if (done[d]) bad++;
         n++;
         tick();
      end
      check("vec_sched", bad, 0);
      nbusy = n;
   endtask

   initial begin
      int nb;
      checks = 0;
      errors = 0;
      for (int i = 0; i < 4; i++) begin
         start[i] = 1'b0;
         abort[i] = 1'b0;
      end
      rst_n = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         check("rst_busy", busy[i], 0);
         check("rst_done", done[i], 0);
         check("rst_pass", pass[i], 0);
         check("rst_gate", {ga[i], gb[i]}, 0);
         check("rst_err", errc[i], 0);
         check("rst_fv", fail_valid[i], 0);
      end
      #3 rst_n = 1'b1;
      tick();

      // correct gate, H4 L1
      pulse_start(0);
      run_to_end(0, 4, 0, nb);
      check("t1_busy_len", nb, 16);
      check("t1_done", done[0], 1);
      check("t1_pass", pass[0], 1);
      check("t1_err", errc[0], 0);
      check("t1_fv", fail_valid[0], 0);
      check("t1_gate_done", {ga[0], gb[0]}, 0);
      tick();
      check("t1_done_pulse", done[0], 0);
      check("t1_pass_held", pass[0], 1);

      // stuck-at-1, H2: 00, 01, 10 mismatch
      pulse_start(1);
      run_to_end(1, 2, 0, nb);
      check("t2_busy_len", nb, 8);
      check("t2_done", done[1], 1);
      check("t2_err", errc[1], 3);
      check("t2_fvec", fvec[1], 0);
      check("t2_fv", fail_valid[1], 1);
      check("t2_pass", pass[1], 0);
      tick();

      // abort on the first sample edge still scores that sample
      pulse_start(1);
      tick();
      abort[1] = 1'b1;
      tick();
      abort[1] = 1'b0;
      check("t2a_busy", busy[1], 0);
      check("t2a_done", done[1], 0);
      check("t2a_err", errc[1], 1);
      check("t2a_fv", fail_valid[1], 1);

      // OR gate, L2: 01 and 10 mismatch in both sweeps
      pulse_start(2);
      run_to_end(2, 4, 0, nb);
      check("t3_busy_len", nb, 32);
      check("t3_done", done[2], 1);
      check("t3_err", errc[2], 4);
      check("t3_fvec", fvec[2], 1);
      check("t3_pass", pass[2], 0);
      tick();

      // stuck-at-0, ERR_W 2, L4: four mismatches saturate at 3
      pulse_start(3);
      run_to_end(3, 4, 0, nb);
      check("t4_busy_len", nb, 64);
      check("t4_done", done[3], 1);
      check("t4_err_sat", errc[3], 3);
      check("t4_fvec", fvec[3], 3);
      check("t4_pass", pass[3], 0);
      tick();

      // abort in RUN cycle 6, then a clean rerun
      pulse_start(0);
      repeat (6) tick();
      check("t5_vec_c6", {ga[0], gb[0]}, 1);
      abort[0] = 1'b1;
      tick();
      abort[0] = 1'b0;
      check("t5_busy", busy[0], 0);
      check("t5_done", done[0], 0);
      check("t5_gate", {ga[0], gb[0]}, 0);
      check("t5_pass", pass[0], 0);
      tick();
      check("t5_no_done", done[0], 0);
      pulse_start(0);
      run_to_end(0, 4, 0, nb);
      check("t5_busy_len", nb, 16);
      check("t5_done2", done[0], 1);
      check("t5_pass2", pass[0], 1);
      tick();

      // asynchronous reset mid-run
      pulse_start(0);
      repeat (10) tick();
      check("t6_pre_busy", busy[0], 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_busy", busy[0], 0);
      check("t6_gate", {ga[0], gb[0]}, 0);
      check("t6_done", done[0], 0);
      check("t6_pass", pass[0], 0);
      check("t6_err_other", errc[1], 0);
      check("t6_fv_other", fail_valid[1], 0);
      #3 rst_n = 1'b1;
      tick();
      check("t6_no_done", done[0], 0);

      // start with abort in IDLE is refused
      start[0] = 1'b1;
      abort[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      abort[0] = 1'b0;
      check("t6_sa_busy", busy[0], 0);
      tick();
      check("t6_sa_idle", busy[0] | done[0], 0);

      // start during RUN leaves the counters alone
      pulse_start(0);
      repeat (4) tick();
      pulse_start(0);
      run_to_end(0, 4, 5, nb);
      check("t6_rs_len", nb, 16);
      check("t6_rs_done", done[0], 1);
      check("t6_rs_pass", pass[0], 1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
